csr_bank: RTL and testbench

CSR_BANK -- requirements
Module: csr_bank

---
 rtl/csr_bank.sv | 170 +++++++++++++++++
 tb/tb_csr_bank.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_bank.sv
// Control/status register bank: ID/version, system control, scratch, data-plane
// status/counters, LED and synchronized switches. Define CSR_IRQ_EN to add IRQ_PEND/IRQ_MASK and irq.
module csr_bank #(
  parameter int unsigned DW        = 8,
  parameter int unsigned N_SCRATCH = 2,
  parameter logic [7:0]  DEVICE_ID = 8'hA7,
  parameter logic [15:0] VERSION   = 16'h0200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    reg_addr,
  input  logic [DW-1:0] reg_wdata,
  input  logic          reg_wr,
  input  logic          reg_rd,
  output logic [DW-1:0] reg_rdata,
  output logic          reg_rvalid,
  output logic [DW-1:0] led_out,
  input  logic [DW-1:0] sw_in,
  input  logic          spi_active,
  input  logic          spi_rx_valid,
  input  logic [7:0]    spi_rx_byte,
  input  logic          spi_err,
  output logic          irq
);

  localparam logic [7:0] A_ID          = 8'h00;
  localparam logic [7:0] A_VER_MAJ     = 8'h01;
  localparam logic [7:0] A_VER_MIN     = 8'h02;
  localparam logic [7:0] A_SYS_STATUS  = 8'h03;
  localparam logic [7:0] A_SYS_CTRL    = 8'h04;
  localparam logic [7:0] A_SCRATCH     = 8'h05;
  localparam logic [7:0] A_DATA_STATUS = 8'h13;
  localparam logic [7:0] A_DATA_ERR    = 8'h14;
  localparam logic [7:0] A_RX_LAST     = 8'h16;
  localparam logic [7:0] A_RX_COUNT    = 8'h17;
  localparam logic [7:0] A_LED         = 8'h20;
  localparam logic [7:0] A_SW_IN       = 8'h22;
`ifdef CSR_IRQ_EN
  localparam logic [7:0] A_IRQ_PEND    = 8'h18;
  localparam logic [7:0] A_IRQ_MASK    = 8'h19;
`endif

  function automatic logic [DW-1:0] zext8(input logic [7:0] v);
    return DW'(v);
  endfunction

  logic [DW-1:0] sys_ctrl;
  logic [DW-1:0] scratch [N_SCRATCH];
  logic [DW-1:0] led_reg;
  logic          error_flag;
  logic [DW-1:0] data_err;
  logic [7:0]    rx_last;
  logic [7:0]    rx_count;
  logic [DW-1:0] sw_meta;
  logic [DW-1:0] sw_sync;
  logic [DW-1:0] rd_mux;
  logic [7:0]    sys_status;
  logic          err_rd_clr;

  assign led_out    = led_reg;
  assign sys_status = {1'b1, spi_active, error_flag, irq, 4'b0000};
  assign err_rd_clr = reg_rd && (reg_addr == A_DATA_ERR);

`ifdef CSR_IRQ_EN
  logic [3:0]    irq_pend;
  logic [DW-1:0] irq_mask;
  logic [DW-1:0] sw_prev;
  logic          act_prev;
  logic [3:0]    irq_events;
  logic [3:0]    irq_w1c;

  assign irq_events = {spi_active & ~act_prev, sw_sync != sw_prev, spi_rx_valid, spi_err};
  assign irq_w1c    = (reg_wr && reg_addr == A_IRQ_PEND) ? reg_wdata[3:0] : 4'b0000;

  // Events are OR-ed in after the W1C mask so a coincident event keeps its bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_pend <= '0;
      irq_mask <= '0;
      sw_prev  <= '0;
      act_prev <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq_pend <= (irq_pend & ~irq_w1c) | irq_events;
      if (reg_wr && reg_addr == A_IRQ_MASK) irq_mask <= reg_wdata;
      sw_prev  <= sw_sync;
      act_prev <= spi_active;
      irq      <= |(irq_pend & irq_mask[3:0]);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // NOTE: default assignment first so every path through the decoder drives rd_mux (no latch).
  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      A_ID:          rd_mux = zext8(DEVICE_ID);
      A_VER_MAJ:     rd_mux = zext8(VERSION[15:8]);
      A_VER_MIN:     rd_mux = zext8(VERSION[7:0]);
      A_SYS_STATUS:  rd_mux = zext8(sys_status);
      A_SYS_CTRL:    rd_mux = sys_ctrl;
      A_DATA_STATUS: rd_mux = zext8({spi_active, 7'b0});
      A_DATA_ERR:    rd_mux = data_err;
      A_RX_LAST:     rd_mux = zext8(rx_last);
      A_RX_COUNT:    rd_mux = zext8(rx_count);
`ifdef CSR_IRQ_EN
      A_IRQ_PEND:    rd_mux = DW'(irq_pend);
      A_IRQ_MASK:    rd_mux = irq_mask;
`endif
      A_LED:         rd_mux = led_reg;
      A_SW_IN:       rd_mux = sw_sync;
      default:       rd_mux = '0;
    endcase
    for (int i = 0; i < int'(N_SCRATCH); i++) begin
      if (reg_addr == 8'(int'(A_SCRATCH) + i)) rd_mux = scratch[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values,
  // which is also what makes a same-cycle read return the pre-write contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_rdata  <= '0;
      reg_rvalid <= 1'b0;
      sys_ctrl   <= '0;
      led_reg    <= '0;
      error_flag <= 1'b0;
      data_err   <= '0;
      rx_last    <= '0;
      rx_count   <= '0;
      sw_meta    <= '0;
      sw_sync    <= '0;
      // NOTE: scratch is a handful of flops, not a RAM macro, so it is reset like any other register.
      for (int i = 0; i < int'(N_SCRATCH); i++) scratch[i] <= '0;
    end else begin
      reg_rvalid <= reg_rd;
      if (reg_rd) reg_rdata <= rd_mux;

      if (reg_wr) begin
        if (reg_addr == A_SYS_CTRL) sys_ctrl <= reg_wdata;
        if (reg_addr == A_LED)      led_reg  <= reg_wdata;
        for (int i = 0; i < int'(N_SCRATCH); i++) begin
          if (reg_addr == 8'(int'(A_SCRATCH) + i)) scratch[i] <= reg_wdata;
        end
      end

      if (spi_err)
        error_flag <= 1'b1;
      else if (reg_wr && reg_addr == A_SYS_STATUS && reg_wdata[5])
        error_flag <= 1'b0;

      // Read-to-clear restarts from the coincident pulse, if any.
      if (err_rd_clr)
        data_err <= spi_err ? DW'(1) : '0;
      else if (spi_err && data_err != '1)
        data_err <= data_err + DW'(1);

      if (spi_rx_valid) begin
        rx_last  <= spi_rx_byte;
        rx_count <= rx_count + 8'd1;
      end

      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

endmodule

// File: tb/tb_csr_bank.sv
// Self-checking bench for csr_bank (DW=8, N_SCRATCH=2): vector table, corner-case sequences,
// and randomized traffic against a behavioural register model. Honors CSR_IRQ_EN.
module tb_csr_bank;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    reg_addr;
  logic [DW-1:0] reg_wdata;
  logic          reg_wr;
  logic          reg_rd;
  logic [DW-1:0] reg_rdata;
  logic          reg_rvalid;
  logic [DW-1:0] led_out;
  logic [DW-1:0] sw_in;
  logic          spi_active;
  logic          spi_rx_valid;
  logic [7:0]    spi_rx_byte;
  logic          spi_err;
  logic          irq;

  csr_bank dut (
    .clk(clk), .rst(rst),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid), .led_out(led_out), .sw_in(sw_in),
    .spi_active(spi_active), .spi_rx_valid(spi_rx_valid), .spi_rx_byte(spi_rx_byte),
    .spi_err(spi_err), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit wr, input bit rd, input logic [7:0] addr, input logic [7:0] wd);
    reg_wr = wr; reg_rd = rd; reg_addr = addr; reg_wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic wr_reg(input logic [7:0] addr, input logic [7:0] wd);
    drive(1'b1, 1'b0, addr, wd); tick(); idle();
  endtask

  task automatic rd_chk(input string name, input logic [7:0] addr, input logic [7:0] exp);
    drive(1'b0, 1'b1, addr, 8'h00); tick(); idle();
    check({name, ".rvalid"}, 16'(reg_rvalid), 16'h1);
    check(name, 16'(reg_rdata), 16'(exp));
  endtask

  task automatic pulse_err();
    spi_err = 1'b1; tick(); spi_err = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] m_ctrl, m_led, m_rx_last, m_mask, m_rdata;
  logic [7:0] m_scr [2];
  logic [7:0] sw_h [3];   // sw_in seen at the last three edges, newest first
  logic [3:0] m_pend;
  int         m_cnt, m_rx_cnt;
  bit         m_flag, m_irq, m_act_prev;

  task automatic model_reset();
    m_ctrl = 0; m_led = 0; m_rx_last = 0; m_mask = 0; m_rdata = 0;
    m_scr[0] = 0; m_scr[1] = 0;
    for (int i = 0; i < 3; i++) sw_h[i] = 0;
    m_pend = 0; m_cnt = 0; m_rx_cnt = 0; m_flag = 0; m_irq = 0; m_act_prev = 0;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a, input bit act);
    case (a)
      8'h00: return 8'hA7;
      8'h01: return 8'h02;
      8'h02: return 8'h00;
      8'h03: return {1'b1, act, m_flag, m_irq, 4'b0000};
      8'h04: return m_ctrl;
      8'h05: return m_scr[0];
      8'h06: return m_scr[1];
      8'h13: return act ? 8'h80 : 8'h00;
      8'h14: return 8'(m_cnt);
      8'h16: return m_rx_last;
      8'h17: return 8'(m_rx_cnt);
`ifdef CSR_IRQ_EN
      8'h18: return {4'b0000, m_pend};
      8'h19: return m_mask;
`endif
      8'h20: return m_led;
      8'h22: return sw_h[1];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step(input bit wr, input bit rd, input logic [7:0] a, input logic [7:0] wd,
                            input bit err, input bit rxv, input logic [7:0] rxb, input bit act,
                            input logic [7:0] sw);
    bit irq_next;
    irq_next = 1'b0;
`ifdef CSR_IRQ_EN
    irq_next = (m_pend & m_mask[3:0]) != 4'b0000;
`endif
    if (wr) begin
      if (a == 8'h03 && wd[5]) m_flag = 1'b0;
      if (a == 8'h04) m_ctrl = wd;
      if (a == 8'h05) m_scr[0] = wd;
      if (a == 8'h06) m_scr[1] = wd;
      if (a == 8'h20) m_led = wd;
`ifdef CSR_IRQ_EN
      if (a == 8'h18) m_pend = m_pend & ~wd[3:0];
      if (a == 8'h19) m_mask = wd;
`endif
    end
    if (err) m_flag = 1'b1;
    if (rd && a == 8'h14) m_cnt = err ? 1 : 0;
    else if (err && m_cnt < 255) m_cnt = m_cnt + 1;
    if (rxv) begin
      m_rx_last = rxb;
      m_rx_cnt  = (m_rx_cnt + 1) % 256;
    end
`ifdef CSR_IRQ_EN
    if (err) m_pend[0] = 1'b1;
    if (rxv) m_pend[1] = 1'b1;
    if (sw_h[1] != sw_h[2]) m_pend[2] = 1'b1;
    if (act && !m_act_prev) m_pend[3] = 1'b1;
`endif
    sw_h[2] = sw_h[1]; sw_h[1] = sw_h[0]; sw_h[0] = sw;
    m_act_prev = act;
    m_irq = irq_next;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [$];

  initial begin
    logic [7:0] raddrs [17];
    tbl.push_back('{0, 1, 8'h00, 8'h00, 8'hA7});
    tbl.push_back('{0, 1, 8'h01, 8'h00, 8'h02});
    tbl.push_back('{0, 1, 8'h02, 8'h00, 8'h00});
    tbl.push_back('{0, 1, 8'h03, 8'h00, 8'h80});
    tbl.push_back('{1, 0, 8'h05, 8'h5A, 8'h00});
    tbl.push_back('{1, 0, 8'h20, 8'hC3, 8'h00});
    tbl.push_back('{0, 1, 8'h05, 8'h00, 8'h5A});
    tbl.push_back('{0, 1, 8'h20, 8'h00, 8'hC3});
    tbl.push_back('{0, 1, 8'h7F, 8'h00, 8'h00});
    tbl.push_back('{1, 0, 8'h06, 8'h11, 8'h00});
    tbl.push_back('{0, 1, 8'h06, 8'h00, 8'h11});
    tbl.push_back('{0, 1, 8'h07, 8'h00, 8'h00});
    tbl.push_back('{1, 0, 8'h04, 8'h3C, 8'h00});
    tbl.push_back('{0, 1, 8'h04, 8'h00, 8'h3C});
    tbl.push_back('{1, 1, 8'h05, 8'h77, 8'h5A});
    tbl.push_back('{0, 1, 8'h05, 8'h00, 8'h77});
    tbl.push_back('{0, 1, 8'h13, 8'h00, 8'h00});
    tbl.push_back('{0, 1, 8'h14, 8'h00, 8'h00});
    tbl.push_back('{0, 1, 8'h16, 8'h00, 8'h00});
    tbl.push_back('{0, 1, 8'h17, 8'h00, 8'h00});
    tbl.push_back('{0, 1, 8'h18, 8'h00, 8'h00});
    tbl.push_back('{0, 1, 8'h19, 8'h00, 8'h00});
    tbl.push_back('{1, 0, 8'h7F, 8'hFF, 8'h00});
    tbl.push_back('{1, 0, 8'h00, 8'h55, 8'h00});
    tbl.push_back('{0, 1, 8'h7F, 8'h00, 8'h00});
    tbl.push_back('{0, 1, 8'h00, 8'h00, 8'hA7});

    raddrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h13,
               8'h14, 8'h16, 8'h17, 8'h18, 8'h19, 8'h20, 8'h22, 8'h7F};

    // ---------------- reset state ----------------
    rst = 1'b1; idle(); sw_in = '0; spi_active = 1'b0; spi_rx_valid = 1'b0;
    spi_rx_byte = '0; spi_err = 1'b0;
    repeat (3) tick();
    check("reset.rdata", 16'(reg_rdata), 16'h0);
    check("reset.rvalid", 16'(reg_rvalid), 16'h0);
    check("reset.irq", 16'(irq), 16'h0);
    check("reset.led_out", 16'(led_out), 16'h0);
    rst = 1'b0;
    tick();

    // ---------------- table ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata);
      tick();
      check($sformatf("tbl[%0d].rvalid", i), 16'(reg_rvalid), 16'(tbl[i].rd));
      if (tbl[i].rd) check($sformatf("tbl[%0d].rdata", i), 16'(reg_rdata), 16'(tbl[i].exp));
    end
    idle(); tick();
    check("tbl.rvalid_drop", 16'(reg_rvalid), 16'h0);
    check("tbl.rdata_hold", 16'(reg_rdata), 16'hA7);
    check("tbl.led_out", 16'(led_out), 16'hC3);

    // ---------------- DATA_ERR saturation and read-clear ----------------
    spi_err = 1'b1;
    repeat (300) tick();
    spi_err = 1'b0;
    rd_chk("data_err.sat", 8'h14, 8'hFF);
    rd_chk("data_err.cleared", 8'h14, 8'h00);
    repeat (3) pulse_err();
    drive(1'b0, 1'b1, 8'h14, 8'h00); spi_err = 1'b1; tick(); idle(); spi_err = 1'b0;
    check("data_err.coincident_old", 16'(reg_rdata), 16'h03);
    rd_chk("data_err.coincident_new", 8'h14, 8'h01);

    // ---------------- error_flag ----------------
    rd_chk("status.err_set", 8'h03, 8'hA0);
    wr_reg(8'h03, 8'hDF);
    rd_chk("status.bit5_zero_keeps", 8'h03, 8'hA0);
    wr_reg(8'h03, 8'h20);
    rd_chk("status.err_cleared", 8'h03, 8'h80);
    drive(1'b1, 1'b0, 8'h03, 8'h20); spi_err = 1'b1; tick(); idle(); spi_err = 1'b0;
    rd_chk("status.set_wins", 8'h03, 8'hA0);
    wr_reg(8'h03, 8'h20);

    // ---------------- RX counters ----------------
    for (int i = 0; i < 257; i++) begin
      spi_rx_valid = 1'b1;
      spi_rx_byte  = (i == 256) ? 8'h3C : 8'(i);
      tick();
    end
    spi_rx_valid = 1'b0;
    rd_chk("rx_count.wrap", 8'h17, 8'h01);
    rd_chk("rx_last", 8'h16, 8'h3C);

    // ---------------- switch synchronizer and spi_active ----------------
    sw_in = 8'h96; tick();
    rd_chk("sw_in.not_yet", 8'h22, 8'h00);
    rd_chk("sw_in.synced", 8'h22, 8'h96);
    spi_active = 1'b1;
    rd_chk("data_status.active", 8'h13, 8'h80);
    rd_chk("status.active", 8'h03, 8'hC0);
    spi_active = 1'b0;

    // ---------------- interrupt path ----------------
`ifdef CSR_IRQ_EN
    repeat (4) tick();
    wr_reg(8'h18, 8'h0F);
    wr_reg(8'h19, 8'h01);
    tick();
    check("irq.idle", 16'(irq), 16'h0);
    pulse_err();
    check("irq.latency", 16'(irq), 16'h0);
    tick();
    check("irq.assert", 16'(irq), 16'h1);
    rd_chk("irq.status", 8'h03, 8'hB0);
    wr_reg(8'h18, 8'h01);
    check("irq.clear_latency", 16'(irq), 16'h1);
    tick();
    check("irq.cleared", 16'(irq), 16'h0);
    pulse_err(); tick();
    check("irq.reassert", 16'(irq), 16'h1);
    drive(1'b1, 1'b0, 8'h18, 8'h01); spi_err = 1'b1; tick(); idle(); spi_err = 1'b0;
    tick(); tick();
    check("irq.set_wins", 16'(irq), 16'h1);
    rd_chk("irq.pend", 8'h18, 8'h01);
`else
    wr_reg(8'h19, 8'hFF);
    wr_reg(8'h18, 8'hFF);
    rd_chk("noirq.pend", 8'h18, 8'h00);
    rd_chk("noirq.mask", 8'h19, 8'h00);
    pulse_err(); tick(); tick();
    check("noirq.irq", 16'(irq), 16'h0);
    rd_chk("noirq.status", 8'h03, 8'hA0);
`endif

    // ---------------- randomized traffic against the model ----------------
    rst = 1'b1; idle(); sw_in = '0; spi_active = 1'b0; spi_err = 1'b0; spi_rx_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2000; i++) begin
      bit wr, rd, err, rxv;
      logic [7:0] a, wd, rxb, exp;
      rd  = ($urandom_range(0, 1) == 1);
      wr  = ($urandom_range(0, 2) == 0);
      a   = raddrs[$urandom_range(0, 16)];
      wd  = 8'($urandom);
      err = ($urandom_range(0, 7) == 0);
      rxv = ($urandom_range(0, 3) == 0);
      rxb = 8'($urandom);
      if ($urandom_range(0, 15) == 0) spi_active = ~spi_active;
      if ($urandom_range(0, 15) == 0) sw_in = 8'($urandom);
      drive(wr, rd, a, wd);
      spi_err = err; spi_rx_valid = rxv; spi_rx_byte = rxb;
      exp = model_read(a, spi_active);
      if (rd) m_rdata = exp;
      model_step(wr, rd, a, wd, err, rxv, rxb, spi_active, sw_in);
      tick();
      check($sformatf("rand[%0d].rvalid", i), 16'(reg_rvalid), 16'(rd));
      check($sformatf("rand[%0d].rdata@%0h", i, a), 16'(reg_rdata), 16'(m_rdata));
      check($sformatf("rand[%0d].led_out", i), 16'(led_out), 16'(m_led));
      check($sformatf("rand[%0d].irq", i), 16'(irq), 16'(m_irq));
    end
    idle(); spi_err = 1'b0; spi_rx_valid = 1'b0;

    // ---------------- reset in the middle of a read ----------------
    drive(1'b0, 1'b1, 8'h05, 8'h00); tick();
    check("midrd.rvalid_before", 16'(reg_rvalid), 16'h1);
    check("midrd.rdata_before", 16'(reg_rdata), 16'(m_scr[0]));
    rst = 1'b1; idle(); spi_active = 1'b0; sw_in = '0; tick();
    check("midrd.rvalid", 16'(reg_rvalid), 16'h0);
    check("midrd.rdata", 16'(reg_rdata), 16'h0);
    check("midrd.irq", 16'(irq), 16'h0);
    drive(1'b1, 1'b1, 8'h20, 8'hFF); spi_err = 1'b1; tick(); idle(); spi_err = 1'b0;
    check("rst_strobe.rvalid", 16'(reg_rvalid), 16'h0);
    check("rst_strobe.led_out", 16'(led_out), 16'h0);
    rst = 1'b0;
    rd_chk("post_rst.sw_in", 8'h22, 8'h00);
    rd_chk("post_rst.id", 8'h00, 8'hA7);
    rd_chk("post_rst.status", 8'h03, 8'h80);
    rd_chk("post_rst.ctrl", 8'h04, 8'h00);
    rd_chk("post_rst.scr0", 8'h05, 8'h00);
    rd_chk("post_rst.scr1", 8'h06, 8'h00);
    rd_chk("post_rst.data_err", 8'h14, 8'h00);
    rd_chk("post_rst.rx_last", 8'h16, 8'h00);
    rd_chk("post_rst.rx_count", 8'h17, 8'h00);
    rd_chk("post_rst.pend", 8'h18, 8'h00);
    rd_chk("post_rst.mask", 8'h19, 8'h00);
    rd_chk("post_rst.led", 8'h20, 8'h00);
    check("post_rst.led_out", 16'(led_out), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
